shift_add_multiplier: RTL and testbench

Multi-cycle unsigned integer multiplier for the mini-cpu execute stage. It sits directly upstream of the ripple_carry_adder and drives its operands. One partial-product add-and-shift step runs per clock, so the adder is reused instead of replicated. Operands enter and the product leaves through valid/ready handshakes.

---
 rtl/shift_add_multiplier_pkg.sv | 17 +
 rtl/ripple_carry_adder.sv | 28 ++
 rtl/shift_add_multiplier.sv | 119 +++++++++++
 tb/tb_shift_add_multiplier.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared mini-cpu constants for the shift-add multiplier.
//   STATE_IDLE / STATE_BUSY / STATE_DONE : fixed state encodings, also seen on
//                                          the dbg_state output of the multiplier
//   mul_state_e                          : multiplier FSM state type
package shift_add_multiplier_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_BUSY = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = STATE_IDLE,
        BUSY = STATE_BUSY,
        DONE = STATE_DONE
    } mul_state_e;

endpackage

// File: rtl/ripple_carry_adder.sv
// Combinational ripple-carry adder used as the multiplier's step adder.
// Ports:
//   a, b  [xlen-1:0] : addends
//   cin              : carry in
//   sum   [xlen-1:0] : a + b + cin, low xlen bits
//   cout             : carry out of the top bit
module ripple_carry_adder #(
    parameter int xlen = 64
) (
    input  logic [xlen-1:0] a,
    input  logic [xlen-1:0] b,
    input  logic            cin,
    output logic [xlen-1:0] sum,
    output logic            cout
);

    always_comb begin
        logic carry;
        sum   = '0;
        carry = cin;
        for (int i = 0; i < xlen; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned shift-add multiplier: one add-and-shift step per clock,
// reusing a single ripple_carry_adder.
// Ports:
//   clk, rstn            : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : operand handshake; a, b sampled on the accepting edge
//   a, b      [xlen-1:0] : unsigned multiplicand / multiplier
//   out_valid / out_ready: product handshake
//   product [2*xlen-1:0] : registered {acc, mq}; valid while out_valid is high
//   busy                 : high while stepping
//   dbg_state [1:0]      : current FSM state encoding
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE and out_valid only in DONE; once out_valid
// rises, product is held stable until the transfer edge.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int xlen = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [xlen-1:0]   a,
    input  logic [xlen-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*xlen-1:0] product,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int CW = (xlen > 1) ? $clog2(xlen) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(xlen - 1);

    mul_state_e      state;
    mul_state_e      state_nx;
    logic [xlen-1:0] mcand;
    logic [xlen-1:0] acc;
    logic [xlen-1:0] mq;
    logic [CW-1:0]   count;
    logic [xlen-1:0] addend;
    logic [xlen-1:0] sum;
    logic            cout;

    // The low multiplier bit selects whether this step adds the multiplicand.
    assign addend = mq[0] ? mcand : '0;

    ripple_carry_adder #(
        .xlen(xlen)
    ) u_step_adder (
        .a   (acc),
        .b   (addend),
        .cin (1'b0),
        .sum (sum),
        .cout(cout)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (count == LAST_STEP) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mcand <= '0;
            acc   <= '0;
            mq    <= '0;
            count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= a;
                        mq    <= b;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                BUSY: begin
                    // Carry-out becomes the new top bit of acc; the bit leaving
                    // acc drops into mq as the multiplier bits shift out.
                    {acc, mq} <= {cout, sum, mq[xlen-1:1]};
                    if (count != LAST_STEP) count <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign product   = {acc, mq};
    assign dbg_state = state;

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

    localparam int XL = 8;
    localparam int XW = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    // ---------------- 8-bit DUT ----------------
    logic            in_valid, out_ready;
    logic [XL-1:0]   a, b;
    logic            in_ready, out_valid, busy;
    logic [2*XL-1:0] product;
    logic [1:0]      dbg_state;

    shift_add_multiplier #(.xlen(XL)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- 64-bit DUT ----------------
    logic            in_valid_w, out_ready_w;
    logic [XW-1:0]   a_w, b_w;
    logic            in_ready_w, out_valid_w, busy_w;
    logic [2*XW-1:0] product_w;
    logic [1:0]      dbg_state_w;

    shift_add_multiplier #(.xlen(XW)) dut_w (
        .clk(clk), .rstn(rstn), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .a(a_w), .b(b_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .product(product_w), .busy(busy_w), .dbg_state(dbg_state_w)
    );

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A transaction accepted at edge t_acc shows its product from edge
    // t_acc+XL onward until the out_valid/out_ready edge; only one in flight.
    function automatic logic [2*XL-1:0] model_mul(input logic [XL-1:0] x, input logic [XL-1:0] y);
        logic [2*XL-1:0] wx, wy;
        wx = {{XL{1'b0}}, x};
        wy = {{XL{1'b0}}, y};
        return wx * wy;
    endfunction

    logic [2*XL-1:0] exp_q[$];
    logic [2*XL-1:0] got_q[$];
    logic [2*XL-1:0] last_prod = '0;
    bit              in_flight = 1'b0;
    int              cyc       = 0;
    int              t_acc     = 0;

    always @(posedge clk or negedge rstn) begin
        bit was_done, was_free;
        if (!rstn) begin
            in_flight = 1'b0;
            exp_q.delete();
            last_prod = '0;
        end else begin
            was_done = in_flight && ((cyc - t_acc) >= XL);
            was_free = !in_flight;
            cyc++;
            if (was_done && out_ready) begin
                last_prod = exp_q.pop_front();
                in_flight = 1'b0;
            end else if (was_free && in_valid) begin
                exp_q.push_back(model_mul(a, b));
                t_acc     = cyc;
                in_flight = 1'b1;
            end
        end
    end

    task automatic compare_cycle();
        bit done;
        done = in_flight && ((cyc - t_acc) >= XL);
        check("in_ready", 128'(in_ready), 128'(!in_flight));
        check("busy", 128'(busy), 128'(in_flight && !done));
        check("out_valid", 128'(out_valid), 128'(done));
        if (done && exp_q.size() > 0) begin
            check("product_done", 128'(product), 128'(exp_q[0]));
        end else if (!in_flight) begin
            check("product_hold", 128'(product), 128'(last_prod));
        end
        if (out_valid && out_ready) got_q.push_back(product);
    endtask

    // ---------------- driver tasks ----------------
    bit rand_ready = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [XL-1:0] x, input logic [XL-1:0] y, input bit keep,
                        output int acc_cyc);
        bit ok;
        ok      = 1'b0;
        acc_cyc = 0;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready && rstn) begin
                tick();
                ok      = 1'b1;
                acc_cyc = cyc;
                break;
            end
            tick();
        end
        if (!keep) in_valid = 1'b0;
        if (!ok) check("send_timeout", 128'(0), 128'(1));
    endtask

    task automatic wait_out(output int edges);
        bit ok;
        ok    = 1'b0;
        edges = 0;
        for (int i = 0; i < 300; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
            edges++;
        end
        if (!ok) check("out_timeout", 128'(0), 128'(1));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int              edges, c1, c2;
        logic [XL-1:0]   rx, ry;
        logic [2*XL-1:0] held;
        logic [XW-1:0]   wa[2], wb[2];
        logic [2*XW-1:0] wexp[2];

        rstn = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        in_valid_w = 1'b0; out_ready_w = 1'b1; a_w = '0; b_w = '0;

        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        // Reset state, with in_valid high to show nothing is taken in reset.
        in_valid = 1'b1; a = 8'd5; b = 8'd5;
        #12;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_product", 128'(product), 128'(0));
        check("rst_state", 128'(dbg_state), 128'(2'd0));
        in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Zero operands: full latency, zero product.
        out_ready = 1'b1;
        send(8'd0, 8'd0, 1'b0, c1);
        wait_out(edges);
        check("zero_latency", 128'(edges), 128'(8));
        check("zero_product", 128'(product), 128'(16'h0000));
        tick();

        // 13*11 with out_ready high: single-cycle out_valid.
        send(8'd13, 8'd11, 1'b0, c1);
        wait_out(edges);
        check("p13x11", 128'(product), 128'(16'h008F));
        tick();
        check("p13x11_valid_drop", 128'(out_valid), 128'(0));
        check("p13x11_in_ready", 128'(in_ready), 128'(1));
        check("p13x11_got", 128'(got_q[$]), 128'(16'h008F));

        // 255*255 with out_ready held low; in_valid during DONE is ignored.
        out_ready = 1'b0;
        send(8'hFF, 8'hFF, 1'b0, c1);
        wait_out(edges);
        check("max_latency", 128'(edges), 128'(8));
        check("max_product", 128'(product), 128'(16'hFE01));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 8'd1; b = 8'd2;
            tick();
            check("hold_valid", 128'(out_valid), 128'(1));
            check("hold_in_ready", 128'(in_ready), 128'(0));
            check("hold_product", 128'(product), 128'(16'hFE01));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("max_released", 128'(out_valid), 128'(0));
        check("max_keep_product", 128'(product), 128'(16'hFE01));
        tick();
        check("ignored_no_busy", 128'(busy), 128'(0));

        // Asynchronous reset in the middle of a multiply.
        send(8'd200, 8'd100, 1'b0, c1);
        tick(); tick(); tick();
        #2;
        rstn = 1'b0;
        #1;
        check("abort_state", 128'(dbg_state), 128'(2'd0));
        check("abort_product", 128'(product), 128'(0));
        check("abort_out_valid", 128'(out_valid), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        send(8'd6, 8'd7, 1'b0, c1);
        wait_out(edges);
        check("p6x7", 128'(product), 128'(16'd42));
        tick();

        // Back-to-back with in_valid held high.
        out_ready = 1'b1;
        send(8'd3, 8'd5, 1'b1, c1);
        send(8'd9, 8'd9, 1'b0, c2);
        check("issue_interval", 128'(c2 - c1), 128'(XL + 2));
        check("b2b_first", 128'(got_q[$]), 128'(16'd15));
        wait_out(edges);
        check("b2b_second", 128'(product), 128'(16'd81));
        tick();
        check("b2b_got", 128'(got_q[$]), 128'(16'd81));

        // Randomized traffic checked by the model every cycle.
        rand_ready = 1'b1;
        for (int n = 0; n < 25; n++) begin
            rx = ($urandom_range(0, 5) == 0) ? '0 : XL'($urandom_range(0, 255));
            ry = ($urandom_range(0, 5) == 0) ? '1 : XL'($urandom_range(0, 255));
            send(rx, ry, 1'b0, c1);
            for (int g = 0; g < int'($urandom_range(0, 12)); g++) begin
                in_valid = 1'($urandom_range(0, 1));
                a = XL'($urandom_range(0, 255));
                b = XL'($urandom_range(0, 255));
                tick();
            end
            in_valid = 1'b0;
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        held = last_prod;
        check("drain_idle", 128'(in_ready), 128'(1));
        check("drain_product", 128'(product), 128'(held));

        // 64-bit instance: all-ones and one random pair.
        wa[0] = '1; wb[0] = '1;
        wexp[0] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
        wa[1] = {$urandom, $urandom}; wb[1] = {$urandom, $urandom};
        wexp[1] = {64'd0, wa[1]} * {64'd0, wb[1]};
        for (int k = 0; k < 2; k++) begin
            bit ok;
            a_w = wa[k]; b_w = wb[k]; in_valid_w = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (in_ready_w) begin
                    tick();
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            in_valid_w = 1'b0;
            a_w = '0; b_w = '0;
            if (!ok) check("w_send_timeout", 128'(0), 128'(1));
            ok = 1'b0;
            edges = 0;
            for (int i = 0; i < 200; i++) begin
                if (out_valid_w) begin
                    ok = 1'b1;
                    break;
                end
                tick();
                edges++;
            end
            if (!ok) check("w_out_timeout", 128'(0), 128'(1));
            check("w_latency", 128'(edges), 128'(64));
            check("w_product", product_w, wexp[k]);
            tick();
            check("w_in_ready", 128'(in_ready_w), 128'(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
